// File: rtl/alu_arbiter.sv
// Arbiter/sequencer that time-shares one external combinational ALU between NREQ requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority; round-robin otherwise.
module alu_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]        rsp_result,
  output logic [1:0]              rsp_flags,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [1:0]              alu_control,
  input  logic [WIDTH-1:0]        alu_result,
  input  logic [1:0]              alu_flags
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                 r_state;
  logic [NREQ-1:0]        r_gnt;
  logic [NREQ-1:0]        r_rsp_valid;
  logic [WIDTH-1:0]       r_rsp_result;
  logic [1:0]             r_rsp_flags;
  logic [WIDTH-1:0]       r_alu_a;
  logic [WIDTH-1:0]       r_alu_b;
  logic [1:0]             r_alu_control;

  logic [1:0]             w_op [NREQ];
  logic [WIDTH-1:0]       w_a  [NREQ];
  logic [WIDTH-1:0]       w_b  [NREQ];
  logic [IDXW-1:0]        w_win_idx;
  logic                   w_win_found;
  logic [NREQ-1:0]        w_win_oh;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_op[i] = req_op[2*i +: 2];
      w_a[i]  = req_a[WIDTH*i +: WIDTH];
      w_b[i]  = req_b[WIDTH*i +: WIDTH];
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    w_win_idx   = '0;
    w_win_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[IDXW'(k)]) begin
        w_win_idx   = IDXW'(k);
        w_win_found = 1'b1;
      end
    end
  end
`else
  logic [IDXW-1:0] r_rr_ptr;
  logic [IDXW-1:0] w_ptr_next;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int v_idx;
    w_win_idx   = '0;
    w_win_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NREQ) v_idx = v_idx - NREQ;
      if (!w_win_found && req[IDXW'(v_idx)]) begin
        w_win_idx   = IDXW'(v_idx);
        w_win_found = 1'b1;
      end
    end
  end

  assign w_ptr_next = (w_win_idx == IDXW'(NREQ - 1)) ? '0 : w_win_idx + IDXW'(1);
`endif

  assign w_win_oh = NREQ'(1) << w_win_idx;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_gnt         <= '0;
      r_rsp_valid   <= '0;
      r_rsp_result  <= '0;
      r_rsp_flags   <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_control <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_rr_ptr      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_rsp_valid <= '0;
          if (w_win_found) begin
            // Operand registers double as the ALU drive, so they hold through IDLE.
            r_state       <= S_ISSUE;
            r_gnt         <= w_win_oh;
            r_alu_a       <= w_a[w_win_idx];
            r_alu_b       <= w_b[w_win_idx];
            r_alu_control <= w_op[w_win_idx];
`ifndef ALU_ARB_FIXED_PRIO_EN
            r_rr_ptr      <= w_ptr_next;
`endif
          end
        end
        S_ISSUE: begin
          r_state      <= S_RESP;
          r_gnt        <= '0;
          r_rsp_valid  <= r_gnt;
          r_rsp_result <= alu_result;
          r_rsp_flags  <= alu_flags;
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_rsp_valid <= '0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= '0;
          r_rsp_valid <= '0;
        end
      endcase
    end
  end

  assign gnt         = r_gnt;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_result  = r_rsp_result;
  assign rsp_flags   = r_rsp_flags;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_control = r_alu_control;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed stimulus pushes expected grants/responses,
// a negedge monitor pops and compares them including the cycle they appear in.
module tb_alu_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_result;
  logic [1:0]            rsp_flags;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [1:0]            alu_control;
  logic [WIDTH-1:0]      alu_result;
  logic [1:0]            alu_flags;
  logic                  alu_c;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  gnt;
  } gnt_exp_t;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  vld;
    logic [3:0]  res;
    logic [1:0]  flg;
  } rsp_exp_t;

  gnt_exp_t gnt_q[$];
  rsp_exp_t rsp_q[$];

  alu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_flags   (alu_flags)
  );

  // Behavioural ALU: C is carry for add, borrow for sub, 0 for shift.
  always_comb begin
    alu_result = '0;
    alu_c      = 1'b0;
    case (alu_control)
      2'b00:   {alu_c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01:   {alu_c, alu_result} = {1'b0, alu_a} - {1'b0, alu_b};
      2'b11:   alu_result = alu_a << alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
  end
  assign alu_flags = {(alu_result == '0), alu_c};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_gnt(input int at, input logic [1:0] g);
    gnt_exp_t e;
    e.cyc = at;
    e.gnt = g;
    gnt_q.push_back(e);
  endtask

  task automatic push_rsp(input int at, input logic [1:0] v, input logic [3:0] r, input logic [1:0] f);
    rsp_exp_t e;
    e.cyc = at;
    e.vld = v;
    e.res = r;
    e.flg = f;
    rsp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    gnt_exp_t ge;
    rsp_exp_t re;
    if (gnt != '0) begin
      if (gnt_q.size() == 0) check("gnt_unexpected", 32'(gnt), 32'd0);
      else begin
        ge = gnt_q.pop_front();
        check("gnt_value", 32'(gnt), 32'(ge.gnt));
        check("gnt_cycle", cyc, ge.cyc);
      end
    end
    if (rsp_valid != '0) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      else begin
        re = rsp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(re.vld));
        check("rsp_cycle", cyc, re.cyc);
        check("rsp_result", 32'(rsp_result), 32'(re.res));
        check("rsp_flags", 32'(rsp_flags), 32'(re.flg));
      end
    end
    if ((gnt != '0) || (rsp_valid != '0))
      check("gnt_rsp_overlap", 32'(gnt & rsp_valid), 32'd0);
  end

  // Called at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic run_op(input int idx, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_res, input logic [1:0] exp_flg, input bit corrupt_a);
    logic [1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    req_op[2*idx +: 2] = op;
    req_a[4*idx +: 4]  = a;
    req_b[4*idx +: 4]  = b;
    req[idx]           = 1'b1;
    push_gnt(cyc + 1, oh);
    push_rsp(cyc + 2, oh, exp_res, exp_flg);
    @(negedge clk);
    if (corrupt_a) req_a[4*idx +: 4] = 4'b1111;
    @(negedge clk);
    req[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(gnt), 32'd0);
    check({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
    check({tag, "_res"},  32'(rsp_result), 32'd0);
    check({tag, "_flg"},  32'(rsp_flags), 32'd0);
    check({tag, "_alua"}, 32'(alu_a), 32'd0);
    check({tag, "_alub"}, 32'(alu_b), 32'd0);
    check({tag, "_aluc"}, 32'(alu_control), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] w;
    logic [31:0] snap;
    reset_n = 1'b0;
    req     = '0;
    req_op  = '0;
    req_a   = '0;
    req_b   = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_op(0, 2'b00, 4'b1010, 4'b1001, 4'b0011, 2'b01, 1'b0);
    run_op(1, 2'b01, 4'b1101, 4'b1101, 4'b0000, 2'b10, 1'b0);
    run_op(1, 2'b11, 4'b0100, 4'b0010, 4'b0000, 2'b10, 1'b1);

    // Contention: req0 add 0011+0100=0111, req1 sub 0010-0101=1101 with borrow.
    req_op = {2'b01, 2'b00};
    req_a  = {4'b0010, 4'b0011};
    req_b  = {4'b0101, 4'b0100};
    req    = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = 2'b01;
`else
      w = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      push_gnt(cyc + 1 + 3*k, w);
      if (w == 2'b01) push_rsp(cyc + 2 + 3*k, w, 4'b0111, 2'b00);
      else            push_rsp(cyc + 2 + 3*k, w, 4'b1101, 2'b01);
    end
    repeat (11) @(negedge clk);
    req = '0;
    @(negedge clk);

    // Reset during ISSUE: in-flight op must vanish without a response.
    req_op = '0;
    req_a  = {4'b0110, 4'b0001};
    req_b  = {4'b0011, 4'b0001};
    req    = 2'b01;
    push_gnt(cyc + 1, 2'b01);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    req     = 2'b10;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    push_gnt(cyc + 1, 2'b10);
    push_rsp(cyc + 2, 2'b10, 4'b1001, 2'b00);
    repeat (2) @(negedge clk);
    req = '0;
    @(negedge clk);

    snap = {20'd0, gnt, rsp_valid, alu_a, alu_b, alu_control};
    check("idle_alu_a_held", 32'(alu_a), 32'b0110);
    repeat (10) begin
      @(negedge clk);
      check("idle_hold", {20'd0, gnt, rsp_valid, alu_a, alu_b, alu_control}, snap);
    end

    for (int t = 0; t < 20 && (gnt_q.size() != 0 || rsp_q.size() != 0); t++) @(negedge clk);
    check("sb_gnt_drain", gnt_q.size(), 32'd0);
    check("sb_rsp_drain", rsp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that time-shares one combinational `ALU` instance between `NREQ` requesters. It latches the winning requester's operation and operands, drives the ALU, and captures result and flags into registers. It then returns them to the winner with a one-cycle valid pulse. It sits between the instruction-issue logic and the single ALU datapath.

## Interface
- `WIDTH`, 4: ALU operand/result width; must match the `ALU #(WIDTH)` instance.
- `NREQ`, 2: number of requesters, 2..8.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request; held high until its `rsp_valid` bit pulses.
- `req_op`  in  2*NREQ  per-requester ALUControl code; slice i = bits [2i+1:2i].
- `req_a`  in  WIDTH*NREQ  per-requester operand A; slice i = bits [WIDTH*i+WIDTH-1:WIDTH*i].
- `req_b`  in  WIDTH*NREQ  per-requester operand B, same slicing as `req_a`.
- `gnt`  out  NREQ  one-hot grant, high for exactly the ISSUE cycle.
- `rsp_valid`  out  NREQ  one-hot response strobe, high for exactly the RESP cycle.
- `rsp_result`  out  WIDTH  registered ALUResult; valid while any `rsp_valid` bit is high.
- `rsp_flags`  out  2  registered ALUFlags: bit0 = C, bit1 = Z.
- `alu_a`  out  WIDTH  to ALU operand A.
- `alu_b`  out  WIDTH  to ALU operand B.
- `alu_control`  out  2  to ALU control: 00 add, 01 sub, 11 shift-left, 10 unused.
- `alu_result`  in  WIDTH  from ALU.
- `alu_flags`  in  2  from ALU.

## Operation
- FSM states and transitions:
  - IDLE → ISSUE when `req` ≠ 0. Otherwise stay in IDLE.
  - ISSUE → RESP unconditionally.
  - RESP → IDLE unconditionally.
- Arbitration happens in IDLE.
  - Winner = first set `req` bit at or after `rr_ptr`, searching upward modulo NREQ.
  - On the IDLE→ISSUE edge: latch winner index, `req_op`/`req_a`/`req_b` slices into internal registers, and `gnt` (one-hot).
  - Also on that edge: `rr_ptr` ← winner+1, wrapping from NREQ-1 to 0.
- In ISSUE and RESP, `alu_a`/`alu_b`/`alu_control` are driven from the latched registers. In IDLE they hold their last value (0 after reset).
- `rsp_result` and `rsp_flags` are captured from `alu_result`/`alu_flags` on the ISSUE→RESP edge. They hold their value until the next capture.
- In RESP, `rsp_valid[winner]` = 1.
- Operands are latched at grant, so a requester may change `req_*` or drop `req` after `gnt`. The operation still completes and `rsp_valid` still pulses.
- A requester that keeps `req` high through RESP is treated as a new request in the following IDLE cycle.
- Op 10 is passed to the ALU unchanged. Result and flags are whatever the ALU returns.
- No arithmetic inside the block. Widths are passed through unmodified.

## Timing
- Reset values, with `reset_n` low asynchronously:
  - state = IDLE, `rr_ptr` = 0.
  - `gnt`, `rsp_valid`, `rsp_result`, `rsp_flags`, `alu_a`, `alu_b`, `alu_control` = 0.
- Reset mid-operation: any in-flight op is dropped and no `rsp_valid` is issued. Arbitration restarts from requester 0 on the first edge after deassertion.
- Latency: `req` sampled high at edge 0 gives `gnt` high in cycle 1 (ISSUE) and `rsp_valid` high in cycle 2 (RESP).
- Throughput: one operation per 3 cycles. Back-to-back grants are separated by one IDLE cycle.
- The ALU has one full cycle (ISSUE) for its combinational path.
- `gnt` and `rsp_valid` are registered, glitch-free one-cycle pulses. They are never high in the same cycle.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN` defined: fixed priority.
  - Lowest-index set `req` bit always wins.
  - `rr_ptr` is not implemented.
- `ALU_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described in Operation.

## Test plan
- Add with carry: req[0] with op 00, A=1010, B=1001. Required: `gnt`=01 in cycle 1; `rsp_valid`=01 in cycle 2 with result 0011, C=1, Z=0.
- Sub to zero on requester 1: op 01, A=1101, B=1101. Required: `rsp_valid`=10, result 0000, C=0, Z=1.
- Shift to zero: op 11, A=0100, B=0010. Required: result 0000, Z=1, C=0. Also change `req_a` to 1111 in the ISSUE cycle; the result must be unaffected.
- Contention: req=11 held continuously with distinct operands.
  - Grants must go 01, 10, 01, 10, spaced 3 cycles apart.
  - Each response must carry the correct requester's result.
  - With `ALU_ARB_FIXED_PRIO_EN` defined, grants must be 01 every time.
- Reset mid-op: pull `reset_n` low during ISSUE. Required:
  - All outputs 0 immediately, no `rsp_valid`.
  - After release with req=10 held, `gnt`=10 one cycle later.
- Idle: req=00 for 10 cycles. Required: `gnt`, `rsp_valid` and ALU drive outputs stay constant.
